cdb_arbiter: RTL and testbench
==============================

# cdb_arbiter

Arbitrates up to `N` common-data-bus slots per cycle among functional-unit result requesters (ALU, MULT, LOAD pipes). Each requester holds a completed result until granted. The arbiter selects winners in round-robin order and registers them onto the CDB for the PRF, reservation-station wakeup and ROB completion. It replaces fixed-priority CDB selection and provides per-requester backpressure, so no FU starves.

## Interface

- `NUM_REQ`, default 8: number of requesters (FU result ports).
- `N`, default 2: CDB slots per cycle; legal range 1..`NUM_REQ`.
- `TAG_W`, default 6: PRF tag width.
- `DATA_W`, default 32: result width.
- `ROB_W`, default 5: ROB index width.
- `clock`, input, 1: single clock; all state updates on the rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `squash`, input, 1: mispredict flush; suppresses grants this cycle.
- `req_valid`, input, `NUM_REQ`: requester holds a completed result.
- `req_tag`, input, `NUM_REQ`×`TAG_W`: destination PRF tag per requester.
- `req_data`, input, `NUM_REQ`×`DATA_W`: result value per requester.
- `req_rob_idx`, input, `NUM_REQ`×`ROB_W`: ROB entry per requester.
- `req_grant`, output, `NUM_REQ`: combinational; result is accepted this cycle.
- `cdb_valid`, output, `N`: registered slot valid.
- `cdb_tag`, output, `N`×`TAG_W`: registered slot tag.
- `cdb_data`, output, `N`×`DATA_W`: registered slot data.
- `cdb_rob_idx`, output, `N`×`ROB_W`: registered slot ROB index.
- `cdb_count`, output, $clog2(N+1): registered number of valid slots.
- `rr_ptr_dbg`, output, $clog2(`NUM_REQ`): current round-robin pointer.

## Operation

- **State:** `rr_ptr` plus the output slot registers. No other state.
- **Search order:** scan requesters starting at `rr_ptr`: `rr_ptr`, `rr_ptr+1`, … mod `NUM_REQ`, wrapping past `NUM_REQ-1` to 0. Grant the first `min(N, popcount(req_valid))` valid requesters found.
- **Slot fill:** the k-th granted requester in scan order fills slot k. Slots are filled contiguously from slot 0.
- **Unused slots:** `cdb_valid=0`, with tag, data and rob_idx driven to 0.
- **Pointer update:** if at least one grant, `rr_ptr` ← (index of last granted requester + 1) mod `NUM_REQ`. If no grant, `rr_ptr` is unchanged.
- **Handshake (requester):** must hold valid, tag, data and rob_idx stable until the cycle `req_grant` is high. It may deassert or load a new result in the cycle after a grant.
- **Handshake (arbiter):** `req_grant[i]` is only high when `req_valid[i]` is high.
- **Squash:** `req_grant` is all-zero. The next cycle has all `cdb_valid=0` and `cdb_count=0`. `rr_ptr` is unchanged. Requesters drop their own squashed results.
- **Reset:** `rr_ptr=0`. All `cdb_*` outputs and `cdb_count` are 0. `req_grant` is 0 while reset is high. Reset mid-transfer discards any slot contents; no partial output appears.
- **Duplicate tags:** not checked. A tag of 0 is forwarded like any other tag.

## Timing

- Grant is combinational in cycle t. The result appears on `cdb_*` in cycle t+1 and is held for exactly one cycle.
- Latency is 1 cycle from grant to CDB; throughput is `N` results per cycle.
- An ungranted request waits at most ceil(`NUM_REQ`/`N`)−1 cycles with no squash, given fair round-robin.
- A request raised in cycle t can be granted in cycle t; there is no bubble.
- The first arbitration after reset deasserts uses `rr_ptr=0`.

## Test plan

- **Reset:** assert reset for 2 cycles with all `req_valid=8'hFF` → `req_grant=0`; the cycle after, `cdb_valid=0`, `cdb_count=0`, `rr_ptr_dbg=0`.
- **All requesting, wrap-around:** `NUM_REQ=8`, `N=2`, hold `req_valid=8'hFF`.
  - Grants go to {0,1}, {2,3}, {4,5}, {6,7}, {0,1}.
  - `rr_ptr_dbg` reads 0, 2, 4, 6, 0.
  - The slot order matches the grant order.
- **Sparse requests:** `rr_ptr=6`, `req_valid=8'b0000_1001`.
  - Grant bits 0 and 3.
  - Next cycle: slot0 is req 0 and slot1 is req 3; with tags 5 and 9, `cdb_tag` = {9, 5}.
  - `cdb_count=2`; `rr_ptr` becomes 4.
- **Single request:** `req_valid=8'b0100_0000`, data `32'hDEADBEEF`.
  - Slot0 is valid with `DEADBEEF`; slot1 is invalid with all fields 0.
  - `cdb_count=1`; `rr_ptr=7`.
- **Squash:** all requesting with squash high for one cycle.
  - `req_grant=0`; the next cycle has `cdb_valid=0`; `rr_ptr` is unchanged.
  - The following cycle grants resume from the same `rr_ptr`.
- **Backpressure and stability:** random `req_valid` for 10k cycles, with requesters holding until granted. Check:
  - every request is eventually granted, with wait ≤ 3 cycles when there is no squash;
  - no grant is issued without a valid request;
  - every granted tag, data and rob_idx appears exactly once on the CDB, exactly 1 cycle later.

Source files
------------

// File: rtl/cdb_arbiter.sv
// Round-robin common-data-bus arbiter: grants up to N of NUM_REQ completed results
// per cycle and registers them, in scan order, onto the CDB slots.
module cdb_arbiter #(
    parameter int NUM_REQ = 8,
    parameter int N       = 2,
    parameter int TAG_W   = 6,
    parameter int DATA_W  = 32,
    parameter int ROB_W   = 5
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic                                squash,
    input  logic [NUM_REQ-1:0]                  req_valid,
    input  logic [NUM_REQ-1:0][TAG_W-1:0]       req_tag,
    input  logic [NUM_REQ-1:0][DATA_W-1:0]      req_data,
    input  logic [NUM_REQ-1:0][ROB_W-1:0]       req_rob_idx,
    output logic [NUM_REQ-1:0]                  req_grant,
    output logic [N-1:0]                        cdb_valid,
    output logic [N-1:0][TAG_W-1:0]             cdb_tag,
    output logic [N-1:0][DATA_W-1:0]            cdb_data,
    output logic [N-1:0][ROB_W-1:0]             cdb_rob_idx,
    output logic [$clog2(N+1)-1:0]              cdb_count,
    output logic [$clog2(NUM_REQ)-1:0]          rr_ptr_dbg
);

    localparam int PW = $clog2(NUM_REQ);
    localparam int CW = $clog2(N + 1);
    localparam int SW = PW + 1;
    localparam logic [SW-1:0] NREQ_S = SW'(NUM_REQ);
    localparam logic [CW-1:0] N_C    = CW'(N);

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(NUM_REQ - 1)) ? '0 : p + 1'b1;
    endfunction

    logic [PW-1:0]              rr_ptr;
    logic [PW-1:0]              nxt_ptr;
    logic [NUM_REQ-1:0]         grant_p0;
    logic [N-1:0]               vld_p0;
    logic [N-1:0][TAG_W-1:0]    tag_p0;
    logic [N-1:0][DATA_W-1:0]   data_p0;
    logic [N-1:0][ROB_W-1:0]    rob_p0;
    logic [CW-1:0]              count_p0;

    logic [N-1:0]               vld_p1;
    logic [N-1:0][TAG_W-1:0]    tag_p1;
    logic [N-1:0][DATA_W-1:0]   data_p1;
    logic [N-1:0][ROB_W-1:0]    rob_p1;
    logic [CW-1:0]              count_p1;

    // Stage p0: scan from rr_ptr, k-th winner fills slot k; squash/reset grant nothing
    always_comb begin : arb_scan
        logic [SW-1:0] pos;
        logic [PW-1:0] idx;
        logic [CW-1:0] cnt;
        logic [PW-1:0] last;
        logic          any;
        pos      = '0;
        idx      = '0;
        cnt      = '0;
        last     = rr_ptr;
        any      = 1'b0;
        grant_p0 = '0;
        vld_p0   = '0;
        tag_p0   = '0;
        data_p0  = '0;
        rob_p0   = '0;
        if (!reset && !squash) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                pos = {1'b0, rr_ptr} + SW'(k);
                if (pos >= NREQ_S) pos = pos - NREQ_S;
                idx = pos[PW-1:0];
                if (req_valid[idx] && (cnt < N_C)) begin
                    grant_p0[idx] = 1'b1;
                    for (int s = 0; s < N; s++) begin
                        if (cnt == CW'(s)) begin
                            vld_p0[s]  = 1'b1;
                            tag_p0[s]  = req_tag[idx];
                            data_p0[s] = req_data[idx];
                            rob_p0[s]  = req_rob_idx[idx];
                        end
                    end
                    cnt  = cnt + 1'b1;
                    last = idx;
                    any  = 1'b1;
                end
            end
        end
        count_p0 = cnt;
        nxt_ptr  = any ? ptr_inc(last) : rr_ptr;
    end

    // Stage p1: registered CDB slots, cleared by reset so no partial result escapes
    always_ff @(posedge clock) begin
        if (reset) begin
            rr_ptr   <= '0;
            vld_p1   <= '0;
            tag_p1   <= '0;
            data_p1  <= '0;
            rob_p1   <= '0;
            count_p1 <= '0;
        end else begin
            rr_ptr   <= nxt_ptr;
            vld_p1   <= vld_p0;
            tag_p1   <= tag_p0;
            data_p1  <= data_p0;
            rob_p1   <= rob_p0;
            count_p1 <= count_p0;
        end
    end

    assign req_grant   = grant_p0;
    assign cdb_valid   = vld_p1;
    assign cdb_tag     = tag_p1;
    assign cdb_data    = data_p1;
    assign cdb_rob_idx = rob_p1;
    assign cdb_count   = count_p1;
    assign rr_ptr_dbg  = rr_ptr;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed and randomized-backpressure checks of cdb_arbiter with 8 requesters, 2 slots.
module tb_cdb_arbiter;

    localparam int NUM_REQ = 8;
    localparam int N       = 2;
    localparam int TAG_W   = 6;
    localparam int DATA_W  = 32;
    localparam int ROB_W   = 5;

    logic                           clock = 1'b0;
    logic                           reset = 1'b1;
    logic                           squash = 1'b0;
    logic [NUM_REQ-1:0]             req_valid = '0;
    logic [NUM_REQ-1:0][TAG_W-1:0]  req_tag = '0;
    logic [NUM_REQ-1:0][DATA_W-1:0] req_data = '0;
    logic [NUM_REQ-1:0][ROB_W-1:0]  req_rob_idx = '0;
    logic [NUM_REQ-1:0]             req_grant;
    logic [N-1:0]                   cdb_valid;
    logic [N-1:0][TAG_W-1:0]        cdb_tag;
    logic [N-1:0][DATA_W-1:0]       cdb_data;
    logic [N-1:0][ROB_W-1:0]        cdb_rob_idx;
    logic [1:0]                     cdb_count;
    logic [2:0]                     rr_ptr_dbg;

    int tests_run = 0;
    int tests_failed = 0;

    cdb_arbiter #(
        .NUM_REQ(NUM_REQ), .N(N), .TAG_W(TAG_W), .DATA_W(DATA_W), .ROB_W(ROB_W)
    ) dut (
        .clock(clock), .reset(reset), .squash(squash),
        .req_valid(req_valid), .req_tag(req_tag), .req_data(req_data),
        .req_rob_idx(req_rob_idx), .req_grant(req_grant),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .cdb_rob_idx(cdb_rob_idx), .cdb_count(cdb_count), .rr_ptr_dbg(rr_ptr_dbg)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        squash = 1'b0;
        req_valid = 8'hFF;
        #1;
        tests_run++;
        if (req_grant !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_grant_0: got %h want 00", req_grant);
        end
        step();
        tests_run++;
        if (req_grant !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_grant_1: got %h want 00", req_grant);
        end
        step();
        tests_run++;
        if (cdb_valid !== 2'b00 || cdb_count !== 2'd0 || rr_ptr_dbg !== 3'd0 || req_grant !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_state: valid=%b count=%0d ptr=%0d grant=%h want 00/0/0/00",
                     cdb_valid, cdb_count, rr_ptr_dbg, req_grant);
        end
        reset = 1'b0;
        req_valid = '0;
        #1;
    endtask

    task automatic test_wrap();
        logic [7:0] exp_g [5] = '{8'h03, 8'h0C, 8'h30, 8'hC0, 8'h03};
        int         exp_p [5] = '{0, 2, 4, 6, 0};
        int         base;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_tag[i]     = 6'(i + 10);
            req_data[i]    = 32'h1000 + i;
            req_rob_idx[i] = 5'(i);
        end
        req_valid = 8'hFF;
        #1;
        for (int c = 0; c < 5; c++) begin
            base = 2 * (c % 4);
            tests_run++;
            if (rr_ptr_dbg !== 3'(exp_p[c])) begin
                tests_failed++;
                $display("FAIL wrap_ptr[%0d]: got %0d want %0d", c, rr_ptr_dbg, exp_p[c]);
            end
            tests_run++;
            if (req_grant !== exp_g[c]) begin
                tests_failed++;
                $display("FAIL wrap_grant[%0d]: got %h want %h", c, req_grant, exp_g[c]);
            end
            step();
            if (c == 4) req_valid = '0;
            tests_run++;
            if (cdb_valid !== 2'b11 || cdb_count !== 2'd2 ||
                cdb_tag[0] !== 6'(base + 10) || cdb_tag[1] !== 6'(base + 11) ||
                cdb_data[1] !== 32'h1000 + base + 1 || cdb_rob_idx[0] !== 5'(base)) begin
                tests_failed++;
                $display("FAIL wrap_slots[%0d]: valid=%b count=%0d tag1=%0d tag0=%0d want tag1=%0d tag0=%0d",
                         c, cdb_valid, cdb_count, cdb_tag[1], cdb_tag[0], base + 11, base + 10);
            end
        end
    endtask

    task automatic test_sparse();
        req_valid = 8'h20;
        #1;
        step();
        req_tag[0] = 6'd5;  req_data[0] = 32'hA0; req_rob_idx[0] = 5'd1;
        req_tag[3] = 6'd9;  req_data[3] = 32'hA3; req_rob_idx[3] = 5'd2;
        req_valid = 8'b0000_1001;
        #1;
        tests_run++;
        if (rr_ptr_dbg !== 3'd6 || req_grant !== 8'b0000_1001) begin
            tests_failed++;
            $display("FAIL sparse_grant: ptr=%0d grant=%b want 6 00001001", rr_ptr_dbg, req_grant);
        end
        step();
        req_valid = '0;
        tests_run++;
        if (cdb_tag !== {6'd9, 6'd5} || cdb_valid !== 2'b11 || cdb_count !== 2'd2) begin
            tests_failed++;
            $display("FAIL sparse_slots: tag=%h valid=%b count=%0d want 245 11 2",
                     cdb_tag, cdb_valid, cdb_count);
        end
        tests_run++;
        if (cdb_data[0] !== 32'hA0 || cdb_data[1] !== 32'hA3 || cdb_rob_idx !== {5'd2, 5'd1}) begin
            tests_failed++;
            $display("FAIL sparse_payload: data=%h rob=%h want 000000a3000000a0 041", cdb_data, cdb_rob_idx);
        end
        tests_run++;
        if (rr_ptr_dbg !== 3'd4) begin
            tests_failed++;
            $display("FAIL sparse_ptr: got %0d want 4", rr_ptr_dbg);
        end
    endtask

    task automatic test_single();
        req_tag[6] = 6'd33;
        req_data[6] = 32'hDEADBEEF;
        req_rob_idx[6] = 5'd17;
        req_valid = 8'b0100_0000;
        #1;
        tests_run++;
        if (req_grant !== 8'b0100_0000) begin
            tests_failed++;
            $display("FAIL single_grant: got %b want 01000000", req_grant);
        end
        step();
        req_valid = '0;
        tests_run++;
        if (cdb_valid !== 2'b01 || cdb_data[0] !== 32'hDEADBEEF || cdb_tag[0] !== 6'd33 ||
            cdb_rob_idx[0] !== 5'd17 || cdb_count !== 2'd1) begin
            tests_failed++;
            $display("FAIL single_slot0: valid=%b data=%h tag=%0d rob=%0d count=%0d want 01 deadbeef 33 17 1",
                     cdb_valid, cdb_data[0], cdb_tag[0], cdb_rob_idx[0], cdb_count);
        end
        tests_run++;
        if (cdb_data[1] !== 32'h0 || cdb_tag[1] !== 6'd0 || cdb_rob_idx[1] !== 5'd0) begin
            tests_failed++;
            $display("FAIL single_slot1_zero: data=%h tag=%0d rob=%0d want 0 0 0",
                     cdb_data[1], cdb_tag[1], cdb_rob_idx[1]);
        end
        tests_run++;
        if (rr_ptr_dbg !== 3'd7) begin
            tests_failed++;
            $display("FAIL single_ptr: got %0d want 7", rr_ptr_dbg);
        end
    endtask

    task automatic test_squash();
        for (int i = 0; i < NUM_REQ; i++) req_tag[i] = 6'(i + 10);
        req_tag[7] = 6'd0;
        req_valid = 8'hFF;
        squash = 1'b1;
        #1;
        tests_run++;
        if (req_grant !== 8'h00) begin
            tests_failed++;
            $display("FAIL squash_grant: got %h want 00", req_grant);
        end
        step();
        squash = 1'b0;
        #1;
        tests_run++;
        if (cdb_valid !== 2'b00 || cdb_count !== 2'd0 || rr_ptr_dbg !== 3'd7) begin
            tests_failed++;
            $display("FAIL squash_next: valid=%b count=%0d ptr=%0d want 00 0 7",
                     cdb_valid, cdb_count, rr_ptr_dbg);
        end
        tests_run++;
        if (req_grant !== 8'h81) begin
            tests_failed++;
            $display("FAIL squash_resume_grant: got %h want 81", req_grant);
        end
        step();
        req_valid = '0;
        tests_run++;
        if (cdb_valid !== 2'b11 || cdb_tag[0] !== 6'd0 || cdb_tag[1] !== 6'd10 || rr_ptr_dbg !== 3'd1) begin
            tests_failed++;
            $display("FAIL squash_resume_slots: valid=%b tag0=%0d tag1=%0d ptr=%0d want 11 0 10 1",
                     cdb_valid, cdb_tag[0], cdb_tag[1], rr_ptr_dbg);
        end
    endtask

    task automatic test_reset_mid();
        req_valid = 8'hFF;
        #1;
        step();
        reset = 1'b1;
        #1;
        tests_run++;
        if (req_grant !== 8'h00) begin
            tests_failed++;
            $display("FAIL midreset_grant: got %h want 00", req_grant);
        end
        step();
        reset = 1'b0;
        req_valid = '0;
        tests_run++;
        if (cdb_valid !== 2'b00 || cdb_tag !== '0 || cdb_data !== '0 || cdb_rob_idx !== '0 ||
            cdb_count !== 2'd0 || rr_ptr_dbg !== 3'd0) begin
            tests_failed++;
            $display("FAIL midreset_clear: valid=%b tag=%h data=%h count=%0d ptr=%0d want all 0",
                     cdb_valid, cdb_tag, cdb_data, cdb_count, rr_ptr_dbg);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0]             pend = '0;
        int                     waitc [8];
        int                     m_ptr = 0;
        int                     maxw = 0;
        int                     ns;
        int                     last;
        int                     i;
        logic [7:0]             mg;
        logic [1:0]             ev = '0;
        logic [1:0]             ec = '0;
        logic [1:0][TAG_W-1:0]  et = '0;
        logic [1:0][DATA_W-1:0] ed = '0;
        logic [1:0][ROB_W-1:0]  er = '0;
        for (int r = 0; r < NUM_REQ; r++) waitc[r] = 0;
        #1;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            tests_run++;
            if (cdb_valid !== ev || cdb_count !== ec || cdb_tag !== et || cdb_data !== ed ||
                cdb_rob_idx !== er || rr_ptr_dbg !== 3'(m_ptr)) begin
                tests_failed++;
                $display("FAIL rand_cdb[%0d]: valid=%b tag=%h data=%h ptr=%0d want %b %h %h %0d",
                         cyc, cdb_valid, cdb_tag, cdb_data, rr_ptr_dbg, ev, et, ed, m_ptr);
            end
            for (int r = 0; r < NUM_REQ; r++) begin
                if (!pend[r] && ($urandom_range(0, 1) == 1)) begin
                    pend[r] = 1'b1;
                    waitc[r] = 0;
                    req_tag[r] = 6'($urandom);
                    req_data[r] = $urandom;
                    req_rob_idx[r] = 5'($urandom);
                end
            end
            req_valid = pend;
            #1;
            mg = '0; ev = '0; et = '0; ed = '0; er = '0; ns = 0; last = -1;
            for (int k = 0; k < NUM_REQ; k++) begin
                i = (m_ptr + k) % NUM_REQ;
                if (pend[i] && ns < N) begin
                    mg[i] = 1'b1;
                    ev[ns] = 1'b1;
                    et[ns] = req_tag[i];
                    ed[ns] = req_data[i];
                    er[ns] = req_rob_idx[i];
                    ns++;
                    last = i;
                end
            end
            ec = 2'(ns);
            if (last >= 0) m_ptr = (last + 1) % NUM_REQ;
            tests_run++;
            if (req_grant !== mg) begin
                tests_failed++;
                $display("FAIL rand_grant[%0d]: got %b want %b", cyc, req_grant, mg);
            end
            tests_run++;
            if ((req_grant & ~req_valid) !== 8'h00) begin
                tests_failed++;
                $display("FAIL rand_grant_no_req[%0d]: grant=%b valid=%b", cyc, req_grant, req_valid);
            end
            for (int r = 0; r < NUM_REQ; r++) begin
                if (req_grant[r] === 1'b1) pend[r] = 1'b0;
                else if (pend[r]) begin
                    waitc[r]++;
                    if (waitc[r] > maxw) maxw = waitc[r];
                end
            end
            step();
        end
        req_valid = '0;
        tests_run++;
        if (maxw > 3) begin
            tests_failed++;
            $display("FAIL rand_max_wait: got %0d want <= 3", maxw);
        end
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_wrap();
        test_sparse();
        test_single();
        test_squash();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
